// File: rtl/levinson_pkg.sv
// Shared constants and shadow-pipe metadata for the Levinson-Durbin divider client.
package levinson_pkg;

  localparam int DIV_LATENCY    = 8;
  localparam int DIV_NUM_W      = 64;
  localparam int DIV_DEN_W      = 33;
  localparam int DIV_Q_W        = 32;
  localparam int DIV_TAG_W      = 4;
  localparam int RSP_FIFO_DEPTH = 8;

  // Saturated quotients returned for division by zero, chosen by numerator sign.
  localparam logic [DIV_Q_W-1:0] Q_MAX = {1'b0, {(DIV_Q_W-1){1'b1}}};
  localparam logic [DIV_Q_W-1:0] Q_MIN = {1'b1, {(DIV_Q_W-1){1'b0}}};

  typedef struct packed {
    logic                 valid;
    logic [DIV_TAG_W-1:0] tag;
    logic                 dz;
    logic                 sign;
  } div_meta_t;

endpackage

// File: rtl/levinson_sync_fifo.sv
// Non-fall-through synchronous FIFO with wrap-bit pointers; output data reads 0 while empty.
module levinson_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign valid   = (wr_ptr != rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && valid;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/levinson_div_client.sv
// Requester for the fixed-latency pipelined divider: credit-throttled issue, shadow tag pipe, response FIFO.
module levinson_div_client
  import levinson_pkg::*;
#(
  parameter int LATENCY    = DIV_LATENCY,
  parameter int NUM_W      = DIV_NUM_W,
  parameter int DEN_W      = DIV_DEN_W,
  parameter int Q_W        = DIV_Q_W,
  parameter int TAG_W      = DIV_TAG_W,
  parameter int FIFO_DEPTH = RSP_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NUM_W-1:0] req_numer,
  input  logic [DEN_W-1:0] req_denom,
  input  logic [TAG_W-1:0] req_tag,
  output logic [NUM_W-1:0] div_numer,
  output logic [DEN_W-1:0] div_denom,
  input  logic [Q_W-1:0]   div_quotient,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [Q_W-1:0]   rsp_quotient,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dz,
  output logic             busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = Q_W + TAG_W + 1;

  logic [CNT_W-1:0] outstanding;
  div_meta_t        meta [0:LATENCY];
  logic             accept;
  logic             pop;
  logic [Q_W-1:0]   cap_q;
  logic [FW-1:0]    fifo_wdata;
  logic [FW-1:0]    fifo_rdata;

  // Credits cover both in-flight and queued results, so the FIFO can never overflow.
  assign req_ready = (outstanding < CNT_W'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (outstanding != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      outstanding <= '0;
    end else if (accept && !pop) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (pop && !accept) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  // A zero divisor is replaced by 1 so the divider never sees it; the dz flag overrides the result.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_numer <= '0;
      div_denom <= '0;
    end else if (accept) begin
      div_numer <= req_numer;
      div_denom <= (req_denom == '0) ? DEN_W'(1) : req_denom;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i <= LATENCY; i++) meta[i] <= '0;
    end else begin
      meta[0] <= '{valid: accept, tag: req_tag, dz: (req_denom == '0), sign: req_numer[NUM_W-1]};
      for (int i = 1; i <= LATENCY; i++) meta[i] <= meta[i-1];
    end
  end

  assign cap_q      = meta[LATENCY].dz ? (meta[LATENCY].sign ? Q_MIN : Q_MAX) : div_quotient;
  assign fifo_wdata = {cap_q, meta[LATENCY].tag, meta[LATENCY].dz};

  levinson_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (meta[LATENCY].valid),
    .wr_data (fifo_wdata),
    .rd_en   (rsp_ready),
    .rd_data (fifo_rdata),
    .valid   (rsp_valid)
  );

  assign {rsp_quotient, rsp_tag, rsp_dz} = fifo_rdata;

endmodule

// File: tb/tb_levinson_div_client.sv
// Self-checking bench: behavioural divider, scoreboard model of the client, directed and random traffic.
module tb_levinson_div_client;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_numer = '0;
  logic [32:0] req_denom = '0;
  logic [3:0]  req_tag = '0;
  logic [63:0] div_numer;
  logic [32:0] div_denom;
  logic [31:0] div_quotient;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_quotient;
  logic [3:0]  rsp_tag;
  logic        rsp_dz;
  logic        busy;

  int n_compared = 0;
  int n_mismatch = 0;

  levinson_div_client dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_numer    (req_numer),
    .req_denom    (req_denom),
    .req_tag      (req_tag),
    .div_numer    (div_numer),
    .div_denom    (div_denom),
    .div_quotient (div_quotient),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_quotient (rsp_quotient),
    .rsp_tag      (rsp_tag),
    .rsp_dz       (rsp_dz),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Stand-in for lpm_divide_var: 8 register stages, no reset, truncating signed division.
  logic [31:0] dpipe [8];
  initial for (int i = 0; i < 8; i++) dpipe[i] = '0;
  always @(posedge clock) begin
    longint dn;
    longint dd;
    dn = $signed(div_numer);
    dd = longint'($signed(div_denom));
    dpipe[0] <= (dd == 0) ? 32'h0 : 32'(dn / dd);
    for (int i = 1; i < 8; i++) dpipe[i] <= dpipe[i-1];
  end
  assign div_quotient = dpipe[7];

  typedef struct {
    logic [31:0] q;
    logic [3:0]  tag;
    logic        dz;
    longint      due;
  } exp_t;

  exp_t   exp_q[$];
  longint edge_no = 0;
  bit     started = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t modelResult(input logic [63:0] n, input logic [32:0] d, input logic [3:0] t, input longint due);
    exp_t   e;
    longint sn;
    longint sd;
    sn    = $signed(n);
    sd    = longint'($signed(d));
    e.dz  = (sd == 0);
    e.q   = e.dz ? ((sn < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'(sn / sd);
    e.tag = t;
    e.due = due;
    return e;
  endfunction

  // Model: every accepted op appears at the FIFO head 9 edges later, in order; credits = queue size.
  always @(posedge clock) begin
    bit head_vis;
    int occ;
    edge_no++;
    if (reset) begin
      exp_q.delete();
      started = 1;
    end else begin
      occ      = exp_q.size();
      head_vis = (occ != 0) && (exp_q[0].due <= edge_no - 1);
      if (head_vis && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && occ < 8) exp_q.push_back(modelResult(req_numer, req_denom, req_tag, edge_no + 9));
    end
  end

  always @(negedge clock) begin
    bit vis;
    if (started) begin
      vis = (exp_q.size() != 0) && (exp_q[0].due <= edge_no);
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(vis));
      checkOutput("req_ready", 64'(req_ready), 64'(exp_q.size() < 8));
      checkOutput("busy", 64'(busy), 64'(exp_q.size() != 0));
      if (vis) begin
        checkOutput("rsp_quotient", 64'(rsp_quotient), 64'(exp_q[0].q));
        checkOutput("rsp_tag", 64'(rsp_tag), 64'(exp_q[0].tag));
        checkOutput("rsp_dz", 64'(rsp_dz), 64'(exp_q[0].dz));
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic applyStimulus(input longint n, input longint d, input logic [3:0] t);
    bit rdy;
    req_valid = 1'b1;
    req_numer = n;
    req_denom = d[32:0];
    req_tag   = t;
    for (int g = 0; g < 100; g++) begin
      rdy = req_ready;
      @(posedge clock);
      @(negedge clock);
      if (rdy) begin
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    checkOutput("accept_timeout", 64'(0), 64'(1));
  endtask

  task automatic directOp(input string name, input longint n, input longint d, input logic [3:0] t,
                          input logic [31:0] q, input logic dz);
    int k;
    applyStimulus(n, d, t);
    k = 0;
    while (k < 40) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      if (rsp_valid) break;
    end
    checkOutput({name, "_latency"}, 64'(k), 64'(9));
    checkOutput({name, "_q"}, 64'(rsp_quotient), 64'(q));
    checkOutput({name, "_tag"}, 64'(rsp_tag), 64'(t));
    checkOutput({name, "_dz"}, 64'(rsp_dz), 64'(dz));
    @(negedge clock);
  endtask

  function automatic longint randNumer();
    return $signed({$urandom, $urandom}) >>> 16;
  endfunction

  function automatic longint randDenom();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 0;
    if (r < 4) return longint'($urandom_range(1, 20)) * (($urandom % 2) ? -1 : 1);
    return longint'($urandom) - 64'sd2147483648;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int     sent;
    longint n;
    longint d;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_rsp_q", 64'(rsp_quotient), 64'(0));
    checkOutput("reset_rsp_tag", 64'(rsp_tag), 64'(0));
    checkOutput("reset_rsp_dz", 64'(rsp_dz), 64'(0));
    checkOutput("reset_div_numer", div_numer, 64'(0));
    checkOutput("reset_div_denom", 64'(div_denom), 64'(0));
    checkOutput("reset_req_ready", 64'(req_ready), 64'(1));

    $display("[TB] directed divisions");
    directOp("p100d7", 100, 7, 4'd3, 32'd14, 1'b0);
    directOp("m100d7", -100, 7, 4'd4, 32'hFFFF_FFF2, 1'b0);
    directOp("p100dm7", 100, -7, 4'd5, 32'hFFFF_FFF2, 1'b0);
    directOp("z0d5", 0, 5, 4'd6, 32'd0, 1'b0);
    directOp("p5d0", 5, 0, 4'd7, 32'h7FFF_FFFF, 1'b1);
    directOp("m5d0", -5, 0, 4'd8, 32'h8000_0000, 1'b1);
    directOp("p9d3", 9, 3, 4'd9, 32'd3, 1'b0);

    $display("[TB] 20 back-to-back with stalled consumer");
    rsp_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 200 && sent < 20; c++) begin
      bit rdy;
      if (c == 20) begin
        checkOutput("accepts_before_stall", 64'(sent), 64'(8));
        checkOutput("req_ready_stalled", 64'(req_ready), 64'(0));
        rsp_ready = 1'b1;
      end
      req_valid = 1'b1;
      req_numer = 1000 + sent * 37;
      req_denom = 33'(sent + 1);
      req_tag   = 4'(sent);
      rdy = req_ready;
      @(posedge clock);
      @(negedge clock);
      if (rdy) sent++;
    end
    req_valid = 1'b0;
    checkOutput("stream_sent", 64'(sent), 64'(20));
    idle(30);
    checkOutput("stream_drained", 64'(busy), 64'(0));

    $display("[TB] full FIFO with simultaneous pop and accept");
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(randNumer(), 11, 4'(i));
    idle(12);
    checkOutput("full_req_ready", 64'(req_ready), 64'(0));
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      req_valid = 1'b1;
      req_numer = randNumer();
      req_denom = 33'(c + 2);
      req_tag   = 4'(c);
      @(posedge clock);
      @(negedge clock);
      if (c == 0) checkOutput("ready_after_first_pop", 64'(req_ready), 64'(1));
    end
    req_valid = 1'b0;
    idle(25);

    $display("[TB] reset with ops in flight and queued");
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(50 + i, 3, 4'(i));
    idle(10);
    for (int i = 0; i < 5; i++) applyStimulus(70 + i, 4, 4'(i + 3));
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midreset_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_req_ready", 64'(req_ready), 64'(1));
    rsp_ready = 1'b1;
    directOp("p42d6", 42, 6, 4'd10, 32'd7, 1'b0);
    idle(15);
    checkOutput("after_reset_idle", 64'(busy), 64'(0));

    $display("[TB] random traffic");
    for (int c = 0; c < 600; c++) begin
      n = randNumer();
      d = randDenom();
      req_valid = ($urandom % 3) != 0;
      req_numer = n;
      req_denom = d[32:0];
      req_tag   = 4'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      @(negedge clock);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    idle(30);
    checkOutput("random_drained", 64'(busy), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
